vdp_super_vram_port: RTL and testbench
======================================

// Module: vdp_super_vram_port
// PURPOSE
//  Upstream VRAM slot scheduler for the super-res renderer. Turns the renderer's 17-bit word address
//  into 32-bit reads and returns vrm_32 within the 4-clock pixel group.
//  Interleaves CPU byte accesses and SDRAM refresh into the free slots.
//  Sits between the renderer/CPU port and the fixed-latency 32-bit SDRAM controller.
// PARAMETERS
//  RD_LATENCY     2   mem_req -> mem_rdata valid, in clocks; legal 1..3 (elaboration error otherwise)
//  REFRESH_SLOTS  16  FS slots between forced refreshes (>=2)
// PORTS
//  clk                  in   1   pixel clock
//  reset                in   1   synchronous, active-high
//  vdp_super            in   1   super modes enabled
//  cx                   in   11  horizontal counter; cx[1:0] = slot phase
//  super_res_drawing    in   1   renderer fetch window active
//  super_res_vram_addr  in   17  renderer word address
//  vrm_32               out  32  last renderer read word
//  cpu_req              in   1   CPU access request, level, held until cpu_ack
//  cpu_we               in   1   1 = write
//  cpu_addr             in   19  CPU byte address
//  cpu_wdata            in   8   write byte
//  cpu_rdata            out  8   read byte, valid with cpu_ack
//  cpu_ack              out  1   1-clock completion pulse
//  mem_req              out  1   1-clock command strobe
//  mem_we               out  1   write command
//  mem_refresh          out  1   refresh command (mem_req=0)
//  mem_addr             out  17  word address
//  mem_wdata            out  32  write data, byte replicated
//  mem_be               out  4   byte enables, one-hot for CPU writes
//  mem_rdata            in   32  read data, valid exactly RD_LATENCY clocks after mem_req
// BEHAVIOUR
//  Reset: all outputs 0; busy, pending read, and refresh count cleared; an in-flight read is discarded.
//  Slot phase from cx[1:0]: 0 DL, 1 DA, 2 AP, 3 FS.
//   DA + vdp_super + super_res_drawing: renderer read; mem_addr=super_res_vram_addr, mem_be=4'hF.
//     Capture mem_rdata into vrm_32 exactly RD_LATENCY clocks later.
//     vrm_32 then holds until the next renderer capture, so it is valid by the next DA.
//   DA with no renderer read (window off or vdp_super=0): slot becomes a CPU slot.
//   FS: refresh if the refresh counter has reached REFRESH_SLOTS-1, else a CPU slot.
//     The refresh counter counts FS slots and clears on refresh. Refresh beats CPU; CPU waits.
//   DL, AP: no command issued.
//  CPU handshake:
//   - Accept when cpu_req=1, not busy, in a CPU slot, and not the clock after cpu_ack.
//     On accept, latch cpu_we, cpu_addr, cpu_wdata and set busy.
//   - Write: mem_be = 1<<cpu_addr[1:0]; mem_addr = cpu_addr[18:2];
//     mem_wdata = {4{cpu_wdata}}; cpu_ack pulses the next clock.
//   - Read: cpu_rdata = mem_rdata byte cpu_addr[1:0] (byte 0 = bits[7:0]);
//     cpu_ack pulses in the same clock as the data capture.
//   - Only one CPU operation is outstanding. cpu_req that is still high in the clock after cpu_ack
//     is treated as a new request.
//  A renderer read and a CPU read never share a capture clock: slots are 2 apart, latency <=3.
//  A vdp_super falling edge mid-group completes in-flight reads normally.
//  mem_addr, mem_we, mem_be, mem_wdata are only meaningful while mem_req=1.
// CONFIGURATION
//  SUPER_VRAM_CPU_CACHE_EN defined: one-word CPU read cache (tag 17b + data 32b + valid).
//   - A read hitting a valid tag acks the next clock without using a slot.
//   - A CPU read miss fills the cache.
//   - A CPU write to the cached word invalidates it.
//   - Reset invalidates it.
//  Undefined: every CPU read uses a slot; there is no cache logic.
// STRUCTURE
//  Shared package vdp_super_vram_pkg:
//   - typedef enum logic [1:0] slot_phase_t {SLOT_DL, SLOT_DA, SLOT_AP, SLOT_FS}
//   - typedef enum slot_owner_t {OWN_NONE, OWN_RENDER, OWN_CPU, OWN_REFRESH}
//   - localparam VRAM_WORD_AW = 17
//  Sub-module vdp_super_refresh_timer: FS-slot counter, refresh_due output, clear input.
//  Read return path: RD_LATENCY-deep shift register of slot_owner_t plus byte select, in this module.
// TESTING
//  1 RD_LATENCY=2, drawing=1, addr 0x00010 at cx=1; mem_rdata=0xAABBCCDD at cx=3 -> vrm_32=0xAABBCCDD at cx=4, held to cx=7.
//  2 drawing=1, CPU write addr 0x00006 data 0x5A -> serviced in FS; mem_be=4'b0100, mem_addr=1, mem_wdata=0x5A5A5A5A; cpu_ack next clock.
//  3 drawing=0, CPU read addr 0x00003, mem word 0x11223344 -> issued at the first DA/FS; cpu_rdata=0x11; no vrm_32 change.
//  4 REFRESH_SLOTS=16, CPU req held continuously -> mem_refresh once per 16 FS slots; CPU never wins that slot; no ack lost or duplicated.
//  5 reset asserted 1 clock after a renderer mem_req -> no capture; vrm_32=0, cpu_ack=0; first post-reset DA fetch is normal.
//  6 SUPER_VRAM_CPU_CACHE_EN: reads at 0x00004 then 0x00005 -> second acks 1 clock after req with no mem_req; a write to 0x00006 invalidates; next read misses.

Source files
------------

// File: rtl/vdp_super_vram_pkg.sv
// Shared types for the super-res VRAM slot scheduler: slot phases, slot owners, read-return tags.
package vdp_super_vram_pkg;

   localparam int VRAM_WORD_AW = 17;

   typedef enum logic [1:0] {SLOT_DL, SLOT_DA, SLOT_AP, SLOT_FS} slot_phase_t;

   typedef enum logic [1:0] {OWN_NONE, OWN_RENDER, OWN_CPU, OWN_REFRESH} slot_owner_t;

   // One entry of the read-return pipeline: who issued the slot and which byte the CPU wants.
   typedef struct packed {
      slot_owner_t owner;
      logic [1:0]  bsel;
   } rd_tag_t;

   function automatic logic [7:0] byte_of(input logic [31:0] word, input logic [1:0] sel);
      return word[{sel, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/vdp_super_refresh_timer.sv
// Counts FS slots and flags when the next FS slot must be spent on an SDRAM refresh.
module vdp_super_refresh_timer
   import vdp_super_vram_pkg::*;
#(
   parameter int unsigned REFRESH_SLOTS = 16
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic fs_slot_i,
   input  logic clear_i,
   output logic refresh_due_o
);

   localparam int unsigned CW = $clog2(REFRESH_SLOTS);

   if (REFRESH_SLOTS < 2) begin : g_bad_slots
      $error("vdp_super_refresh_timer: REFRESH_SLOTS must be >= 2");
   end

   logic [CW-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (fs_slot_i) begin
         count_d = clear_i ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign refresh_due_o = (count_q == CW'(REFRESH_SLOTS - 1));

endmodule

// File: rtl/vdp_super_vram_port.sv
// VRAM slot scheduler: renderer 32-bit fetches in DA, CPU byte accesses and refresh in free slots.
// Optional one-word CPU read cache enabled by defining SUPER_VRAM_CPU_CACHE_EN.
module vdp_super_vram_port
   import vdp_super_vram_pkg::*;
#(
   parameter int unsigned RD_LATENCY    = 2,
   parameter int unsigned REFRESH_SLOTS = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    vdp_super,
   input  logic [10:0]             cx,
   input  logic                    super_res_drawing,
   input  logic [VRAM_WORD_AW-1:0] super_res_vram_addr,
   output logic [31:0]             vrm_32,
   input  logic                    cpu_req,
   input  logic                    cpu_we,
   input  logic [18:0]             cpu_addr,
   input  logic [7:0]              cpu_wdata,
   output logic [7:0]              cpu_rdata,
   output logic                    cpu_ack,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic                    mem_refresh,
   output logic [VRAM_WORD_AW-1:0] mem_addr,
   output logic [31:0]             mem_wdata,
   output logic [3:0]              mem_be,
   input  logic [31:0]             mem_rdata
);

   if (RD_LATENCY < 1 || RD_LATENCY > 3) begin : g_bad_latency
      $error("vdp_super_vram_port: RD_LATENCY must be 1..3");
   end

   slot_phase_t phase;
   logic        render_rd, refresh_due, refresh_slot, cpu_slot, cpu_can, cpu_issue, cpu_hit_acc;
   logic        unused_cx;
   rd_tag_t     issue_tag;
   rd_tag_t     rd_pipe_q [RD_LATENCY];
   logic        busy_q, cpu_ack_q;
   logic [7:0]  cpu_rdata_q;
   logic [31:0] vrm_q;

   assign phase     = slot_phase_t'(cx[1:0]);
   assign unused_cx = ^cx[10:2];

   assign render_rd    = (phase == SLOT_DA) && vdp_super && super_res_drawing;
   assign refresh_slot = (phase == SLOT_FS) && refresh_due;
   assign cpu_slot     = ((phase == SLOT_DA) && !render_rd) || ((phase == SLOT_FS) && !refresh_due);
   assign cpu_can      = cpu_req && !busy_q && !cpu_ack_q;

`ifdef SUPER_VRAM_CPU_CACHE_EN
   logic                    cache_valid_q;
   logic [VRAM_WORD_AW-1:0] cache_tag_q, cpu_tag_q;
   logic [31:0]             cache_data_q;
   logic                    cache_hit;

   assign cache_hit   = cache_valid_q && (cache_tag_q == cpu_addr[18:2]);
   assign cpu_hit_acc = cpu_can && !cpu_we && cache_hit;
   assign cpu_issue   = cpu_can && cpu_slot && !cpu_hit_acc;
`else
   assign cpu_hit_acc = 1'b0;
   assign cpu_issue   = cpu_can && cpu_slot;
`endif

   vdp_super_refresh_timer #(
      .REFRESH_SLOTS(REFRESH_SLOTS)
   ) u_refresh_timer (
      .clk_i        (clk),
      .reset_i      (reset),
      .fs_slot_i    (phase == SLOT_FS),
      .clear_i      (refresh_due),
      .refresh_due_o(refresh_due)
   );

   // Commands go out in the slot's own clock so mem_rdata lands RD_LATENCY clocks after cx phase DA/FS.
   always_comb begin
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_refresh = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_be      = '0;
      issue_tag   = '{owner: OWN_NONE, bsel: 2'b00};
      if (!reset) begin
         if (render_rd) begin
            mem_req   = 1'b1;
            mem_addr  = super_res_vram_addr;
            mem_be    = 4'hF;
            issue_tag = '{owner: OWN_RENDER, bsel: 2'b00};
         end else if (refresh_slot) begin
            mem_refresh = 1'b1;
            issue_tag   = '{owner: OWN_REFRESH, bsel: 2'b00};
         end else if (cpu_issue) begin
            mem_req  = 1'b1;
            mem_we   = cpu_we;
            mem_addr = cpu_addr[18:2];
            if (cpu_we) begin
               mem_be    = 4'b0001 << cpu_addr[1:0];
               mem_wdata = {4{cpu_wdata}};
            end else begin
               mem_be    = 4'hF;
               issue_tag = '{owner: OWN_CPU, bsel: cpu_addr[1:0]};
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            rd_pipe_q[i] <= '{owner: OWN_NONE, bsel: 2'b00};
         end
         busy_q      <= 1'b0;
         cpu_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
         vrm_q       <= '0;
`ifdef SUPER_VRAM_CPU_CACHE_EN
         cache_valid_q <= 1'b0;
         cache_tag_q   <= '0;
         cache_data_q  <= '0;
         cpu_tag_q     <= '0;
`endif
      end else begin
         rd_pipe_q[0] <= issue_tag;
         for (int unsigned i = 1; i < RD_LATENCY; i++) begin
            rd_pipe_q[i] <= rd_pipe_q[i-1];
         end
         cpu_ack_q <= 1'b0;

         if (cpu_issue) begin
            busy_q    <= !cpu_we;
            cpu_ack_q <= cpu_we;
`ifdef SUPER_VRAM_CPU_CACHE_EN
            cpu_tag_q <= cpu_addr[18:2];
            if (cpu_we && cache_tag_q == cpu_addr[18:2]) begin
               cache_valid_q <= 1'b0;
            end
`endif
         end

`ifdef SUPER_VRAM_CPU_CACHE_EN
         if (cpu_hit_acc) begin
            cpu_ack_q   <= 1'b1;
            cpu_rdata_q <= byte_of(cache_data_q, cpu_addr[1:0]);
         end
`endif

         case (rd_pipe_q[RD_LATENCY-1].owner)
            OWN_RENDER: vrm_q <= mem_rdata;
            OWN_CPU: begin
               cpu_rdata_q <= byte_of(mem_rdata, rd_pipe_q[RD_LATENCY-1].bsel);
               cpu_ack_q   <= 1'b1;
               busy_q      <= 1'b0;
`ifdef SUPER_VRAM_CPU_CACHE_EN
               cache_valid_q <= 1'b1;
               cache_tag_q   <= cpu_tag_q;
               cache_data_q  <= mem_rdata;
`endif
            end
            default: ;
         endcase
      end
   end

   assign vrm_32    = vrm_q;
   assign cpu_rdata = cpu_rdata_q;
   assign cpu_ack   = cpu_ack_q;

endmodule

// File: tb/tb_vdp_super_vram_port.sv
// Directed bench for vdp_super_vram_port (RD_LATENCY=2, REFRESH_SLOTS=16); cache scenario under SUPER_VRAM_CPU_CACHE_EN.
module tb_vdp_super_vram_port;

   logic        clk = 1'b0;
   logic        reset, vdp_super, super_res_drawing, cpu_req, cpu_we;
   logic [10:0] cx;
   logic [16:0] super_res_vram_addr;
   logic [18:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic [31:0] mem_rdata;
   logic [31:0] vrm_32;
   logic [7:0]  cpu_rdata;
   logic        cpu_ack, mem_req, mem_we, mem_refresh;
   logic [16:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   vdp_super_vram_port #(
      .RD_LATENCY   (2),
      .REFRESH_SLOTS(16)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .vdp_super          (vdp_super),
      .cx                 (cx),
      .super_res_drawing  (super_res_drawing),
      .super_res_vram_addr(super_res_vram_addr),
      .vrm_32             (vrm_32),
      .cpu_req            (cpu_req),
      .cpu_we             (cpu_we),
      .cpu_addr           (cpu_addr),
      .cpu_wdata          (cpu_wdata),
      .cpu_rdata          (cpu_rdata),
      .cpu_ack            (cpu_ack),
      .mem_req            (mem_req),
      .mem_we             (mem_we),
      .mem_refresh        (mem_refresh),
      .mem_addr           (mem_addr),
      .mem_wdata          (mem_wdata),
      .mem_be             (mem_be),
      .mem_rdata          (mem_rdata)
   );

   task automatic step;
      @(posedge clk);
      #1 cx = cx + 11'd1;
   endtask

   task automatic do_reset;
      reset = 1'b1;
      cx = '0;
      cpu_req = 1'b0;
      cpu_we = 1'b0;
      super_res_drawing = 1'b0;
      mem_rdata = '0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;
      cx = '0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      vdp_super = 1'b1;
      super_res_drawing = 1'b1;
      super_res_vram_addr = 17'h00123;
      cx = 11'd1;
      cpu_req = 1'b1;
      cpu_we = 1'b0;
      cpu_addr = '0;
      cpu_wdata = '0;
      mem_rdata = 32'hFFFFFFFF;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %0h want 0", mem_req); end
      checks++; if (mem_refresh !== 1'b0) begin errors++; $display("FAIL rst_mem_refresh: got %0h want 0", mem_refresh); end
      checks++; if (vrm_32 !== 32'h0) begin errors++; $display("FAIL rst_vrm_32: got %h want 0", vrm_32); end
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rst_cpu_ack: got %0h want 0", cpu_ack); end
      checks++; if (cpu_rdata !== 8'h0) begin errors++; $display("FAIL rst_cpu_rdata: got %h want 0", cpu_rdata); end
   endtask

   task automatic test_render_read;
      do_reset();
      vdp_super = 1'b1;
      super_res_drawing = 1'b1;
      super_res_vram_addr = 17'h00010;
      step(); #1;  // cx=1 DA
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL t1_req: got %0h want 1", mem_req); end
      checks++; if (mem_addr !== 17'h00010) begin errors++; $display("FAIL t1_addr: got %h want 00010", mem_addr); end
      checks++; if (mem_be !== 4'hF) begin errors++; $display("FAIL t1_be: got %h want F", mem_be); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL t1_we: got %0h want 0", mem_we); end
      step(); mem_rdata = 32'h12345678;  // cx=2
      step(); mem_rdata = 32'hAABBCCDD; #1;  // cx=3
      checks++; if (vrm_32 !== 32'h0) begin errors++; $display("FAIL t1_vrm_early: got %h want 0", vrm_32); end
      step(); mem_rdata = 32'hDEADBEEF;  // cx=4
      for (int c = 4; c <= 7; c++) begin
         #1;
         checks++; if (vrm_32 !== 32'hAABBCCDD) begin errors++; $display("FAIL t1_vrm_cx%0d: got %h want AABBCCDD", c, vrm_32); end
         step(); mem_rdata = 32'h0;
      end
      super_res_drawing = 1'b0;
   endtask

   task automatic test_cpu_write;
      do_reset();
      vdp_super = 1'b1;
      super_res_drawing = 1'b1;
      super_res_vram_addr = 17'h00010;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00006; cpu_wdata = 8'h5A;
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL t2_dl_req: got %0h want 0", mem_req); end
      step(); #1;  // cx=1 DA belongs to the renderer
      checks++; if (mem_we !== 1'b0 || mem_addr !== 17'h00010) begin errors++; $display("FAIL t2_da_owner: got we=%0h addr=%h want we=0 addr=00010", mem_we, mem_addr); end
      step(); step(); #1;  // cx=3 FS
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL t2_fs_cmd: got req=%0h we=%0h want 1 1", mem_req, mem_we); end
      checks++; if (mem_be !== 4'b0100) begin errors++; $display("FAIL t2_be: got %b want 0100", mem_be); end
      checks++; if (mem_addr !== 17'h00001) begin errors++; $display("FAIL t2_addr: got %h want 00001", mem_addr); end
      checks++; if (mem_wdata !== 32'h5A5A5A5A) begin errors++; $display("FAIL t2_wdata: got %h want 5A5A5A5A", mem_wdata); end
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL t2_ack_early: got %0h want 0", cpu_ack); end
      step(); #1;  // cx=4
      checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL t2_ack: got %0h want 1", cpu_ack); end
      cpu_req = 1'b0;
      step(); #1;
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL t2_ack_pulse: got %0h want 0", cpu_ack); end
      super_res_drawing = 1'b0;
   endtask

   task automatic test_cpu_read;
      do_reset();
      vdp_super = 1'b1;
      super_res_drawing = 1'b1;
      super_res_vram_addr = 17'h00040;
      step(); #1;  // cx=1
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL t3_render_req: got %0h want 1", mem_req); end
      step(); super_res_drawing = 1'b0;  // cx=2
      step(); mem_rdata = 32'hCAFEF00D;  // cx=3
      step(); mem_rdata = 32'h0;  // cx=4
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00003;
      #1;
      checks++; if (vrm_32 !== 32'hCAFEF00D) begin errors++; $display("FAIL t3_vrm_pre: got %h want CAFEF00D", vrm_32); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL t3_dl_req: got %0h want 0", mem_req); end
      step(); #1;  // cx=5 DA, window off -> CPU slot
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL t3_issue: got req=%0h we=%0h want 1 0", mem_req, mem_we); end
      checks++; if (mem_addr !== 17'h00000) begin errors++; $display("FAIL t3_addr: got %h want 00000", mem_addr); end
      step(); mem_rdata = 32'h55555555;  // cx=6
      step(); mem_rdata = 32'h11223344; #1;  // cx=7 FS
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL t3_busy_req: got %0h want 0", mem_req); end
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL t3_ack_early: got %0h want 0", cpu_ack); end
      step(); mem_rdata = 32'h0; #1;  // cx=8
      checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL t3_ack: got %0h want 1", cpu_ack); end
      checks++; if (cpu_rdata !== 8'h11) begin errors++; $display("FAIL t3_rdata: got %h want 11", cpu_rdata); end
      checks++; if (vrm_32 !== 32'hCAFEF00D) begin errors++; $display("FAIL t3_vrm_hold: got %h want CAFEF00D", vrm_32); end
      cpu_req = 1'b0;
      step(); #1;
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL t3_ack_pulse: got %0h want 0", cpu_ack); end
   endtask

   task automatic test_refresh;
      logic exp_ref, exp_ack;
      do_reset();
      vdp_super = 1'b1;
      super_res_drawing = 1'b1;
      super_res_vram_addr = 17'h00020;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00008; cpu_wdata = 8'h3C;
      for (int g = 0; g <= 32; g++) begin
         #1;  // DL of group g
         exp_ack = (g > 0) && (((g - 1) % 16) != 15);
         checks++; if (cpu_ack !== exp_ack) begin errors++; $display("FAIL t4_ack_g%0d: got %0h want %0h", g, cpu_ack, exp_ack); end
         if (g < 32) begin
            step(); #1;  // DA
            checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL t4_dup_ack_g%0d: got %0h want 0", g, cpu_ack); end
            step(); step(); #1;  // FS
            exp_ref = ((g % 16) == 15);
            checks++; if (mem_refresh !== exp_ref) begin errors++; $display("FAIL t4_refresh_g%0d: got %0h want %0h", g, mem_refresh, exp_ref); end
            checks++; if (mem_req !== !exp_ref) begin errors++; $display("FAIL t4_cpu_req_g%0d: got %0h want %0h", g, mem_req, !exp_ref); end
            step();
         end
      end
      cpu_req = 1'b0;
      super_res_drawing = 1'b0;
   endtask

   task automatic test_reset_inflight;
      do_reset();
      vdp_super = 1'b1;
      super_res_drawing = 1'b1;
      super_res_vram_addr = 17'h00007;
      step(); #1;  // cx=1
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL t5_req: got %0h want 1", mem_req); end
      step(); reset = 1'b1;  // cx=2
      step(); reset = 1'b0; mem_rdata = 32'h99999999;  // cx=3
      step(); mem_rdata = 32'h0; #1;  // cx=4
      checks++; if (vrm_32 !== 32'h0) begin errors++; $display("FAIL t5_no_capture: got %h want 0", vrm_32); end
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL t5_ack: got %0h want 0", cpu_ack); end
      step(); #1;  // cx=5
      checks++; if (mem_req !== 1'b1 || mem_addr !== 17'h00007) begin errors++; $display("FAIL t5_refetch: got req=%0h addr=%h want 1 00007", mem_req, mem_addr); end
      step(); step(); mem_rdata = 32'h0BADCAFE;  // cx=7
      step(); mem_rdata = 32'h0; #1;  // cx=8
      checks++; if (vrm_32 !== 32'h0BADCAFE) begin errors++; $display("FAIL t5_vrm: got %h want 0BADCAFE", vrm_32); end
      super_res_drawing = 1'b0;
   endtask

`ifdef SUPER_VRAM_CPU_CACHE_EN
   task automatic test_cache;
      do_reset();
      vdp_super = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00004;
      step(); #1;  // cx=1 miss issues
      checks++; if (mem_req !== 1'b1 || mem_addr !== 17'h00001) begin errors++; $display("FAIL t6_miss1: got req=%0h addr=%h want 1 00001", mem_req, mem_addr); end
      step(); step(); mem_rdata = 32'h44332211;  // cx=3
      step(); mem_rdata = 32'h0; #1;  // cx=4
      checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h11) begin errors++; $display("FAIL t6_fill: got ack=%0h rdata=%h want 1 11", cpu_ack, cpu_rdata); end
      cpu_req = 1'b0;
      step(); cpu_req = 1'b1; cpu_addr = 19'h00005; #1;  // cx=5 DA, hit
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL t6_hit_noreq: got %0h want 0", mem_req); end
      step(); #1;  // cx=6
      checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h22) begin errors++; $display("FAIL t6_hit: got ack=%0h rdata=%h want 1 22", cpu_ack, cpu_rdata); end
      cpu_req = 1'b0;
      step(); cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00006; cpu_wdata = 8'h77; #1;  // cx=7 FS
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0100) begin errors++; $display("FAIL t6_write: got req=%0h we=%0h be=%b want 1 1 0100", mem_req, mem_we, mem_be); end
      step(); #1;  // cx=8
      checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL t6_write_ack: got %0h want 1", cpu_ack); end
      cpu_we = 1'b0; cpu_addr = 19'h00004;
      step(); #1;  // cx=9 must miss
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 17'h00001) begin errors++; $display("FAIL t6_miss2: got req=%0h we=%0h addr=%h want 1 0 00001", mem_req, mem_we, mem_addr); end
      step(); #1;  // cx=10
      checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL t6_miss2_early: got %0h want 0", cpu_ack); end
      step(); mem_rdata = 32'h44337711;  // cx=11
      step(); mem_rdata = 32'h0; #1;  // cx=12
      checks++; if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h11) begin errors++; $display("FAIL t6_refill: got ack=%0h rdata=%h want 1 11", cpu_ack, cpu_rdata); end
      cpu_req = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_render_read();
      test_cpu_write();
      test_cpu_read();
      test_refresh();
      test_reset_inflight();
`ifdef SUPER_VRAM_CPU_CACHE_EN
      test_cache();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
